jump_controller: RTL and testbench
==================================

// Module: jump_controller
// PURPOSE
//  Sequences conditional/unconditional control transfer around the existing tester_flags unit.
//  - Holds the architectural flag register (O,S,C,Z).
//  - Accepts one jump request at a time from decode.
//  - Resolves taken/not-taken, drives the PC load and link write.
//  - Flushes wrong-path fetch slots.
//  Sits between decode/ALU and the PC/register-file write port.
// PARAMETERS
//  ADDR_W        16  width of PC, targets and link data
//  FLUSH_CYCLES  2   cycles FLUSH held high after a taken jump (1..7)
// PORTS
//  CLK         in   1       rising-edge clock
//  RESET       in   1       asynchronous, active-low reset
//  FLAG_WE     in   1       ALU writes flags this cycle
//  O_IN,S_IN,C_IN,Z_IN in 1 each  ALU flag results
//  BR_VALID    in   1       decode presents a jump request
//  BR_READY    out  1       controller can accept a request (IDLE only)
//  OP_TF       in   3       000 jf.cond, 001 jt.cond, 010 j, 011 jal, 100 jr, 111 none
//  COND        in   3       000 true, 001 neg(S), 010 zero(Z), 100 carry(C), 101 negzero(S&Z), 111 ovf(O)
//  TARGET      in   ADDR_W  immediate target (jf/jt/j/jal)
//  REG_TARGET  in   ADDR_W  register target (jr)
//  PC_PLUS1    in   ADDR_W  return address of the request
//  PC_LOAD     out  1       one-cycle pulse: PC <= PC_NEXT
//  PC_NEXT     out  ADDR_W  selected target, valid while PC_LOAD=1
//  LINK_WE     out  1       one-cycle pulse with PC_LOAD for jal
//  LINK_DATA   out  ADDR_W  captured PC_PLUS1
//  FLUSH       out  1       kill fetch/decode slots
//  STALL       out  1       hold decode; high whenever BR_READY=0 and BR_VALID=1
//  FLAGS       out  4       {O,S,C,Z} register contents
// BEHAVIOUR
//  - Reset (RESET=0, any cycle, mid-operation included): state IDLE, FLAGS=0, flush count=0.
//    All outputs 0 except BR_READY=1.
//  - Flags register: FLAGS <= {O_IN,S_IN,C_IN,Z_IN} on any edge with FLAG_WE=1, in any state.
//  - Request capture: BR_VALID & BR_READY captures OP_TF, COND, TARGET, REG_TARGET, PC_PLUS1.
//  - States:
//    - IDLE
//      - accept with FLAG_WE=0 -> RESOLVE.
//      - accept with FLAG_WE=1 -> WAITF (the branch must see the new flags).
//    - WAITF: 1 cycle, STALL=1 -> RESOLVE.
//    - RESOLVE: evaluate tester_flags with the registered FLAGS and captured OP_TF/COND.
//      - tester_flags.out=0 means taken.
//      - Taken: PC_LOAD=1. PC_NEXT=REG_TARGET for jr, TARGET otherwise. LINK_WE=1 for jal -> FLUSH.
//      - Not taken: no pulses -> IDLE.
//    - FLUSH: FLUSH=1 for exactly FLUSH_CYCLES cycles (down-counter) -> IDLE.
//  - Latency: accept->PC_LOAD = 1 cycle, or 2 with WAITF. BR_READY returns the cycle after the last FLUSH cycle.
//  - OP_TF 101/110 (illegal) and 111 are treated as never taken.
//  - jf with COND=000 is never taken; jt with COND=000 is always taken.
//  - FLAG_WE during RESOLVE updates FLAGS at the edge. The current decision uses the pre-edge value.
//  - FLUSH_CYCLES outside 1..7 is clamped to 1 at elaboration.
// CONFIGURATION
//  - `JUMP_FLAG_BYPASS_EN defined:
//    - The WAITF state is removed.
//    - A same-cycle FLAG_WE forwards {O_IN,S_IN,C_IN,Z_IN} into the captured flag copy used by RESOLVE.
//    - Latency is always 1 and STALL is not raised for the flag hazard.
//  - Undefined: behaviour exactly as above (WAITF stall).
// STRUCTURE
//  - Shared package/header lapido_defs: OP_TF encodings, COND encodings, state enum (IDLE/WAITF/RESOLVE/FLUSH).
//  - One sub-module: tester_flags, instantiated unchanged for the taken decision.
//  - FSM, flag register, request capture and flush counter are local.
// TESTING
//  - Reset mid-FLUSH:
//    - Stimulus: jal taken, drop RESET in the 1st FLUSH cycle.
//    - Required: FLUSH=0, BR_READY=1, FLAGS=0 immediately (async).
//  - jt.zero, Z=1:
//    - Stimulus: FLAGS=0001 set earlier, then OP_TF=001, COND=010, TARGET=16'h0040.
//    - Required: next cycle PC_LOAD=1, PC_NEXT=0040. FLUSH high 2 cycles, then BR_READY=1.
//  - jf.carry, C=1:
//    - Stimulus: OP_TF=000, COND=100.
//    - Required: not taken. No PC_LOAD, BR_READY=1 two cycles after accept.
//  - jal:
//    - Stimulus: TARGET=0100, PC_PLUS1=0021.
//    - Required: PC_LOAD=LINK_WE=1 same cycle, LINK_DATA=0021, PC_NEXT=0100.
//  - Flag hazard:
//    - Stimulus: FLAG_WE=1 with Z_IN=1 on the same cycle as jt.zero (old Z=0).
//    - Required: one STALL cycle (WAITF), then taken. With `JUMP_FLAG_BYPASS_EN: taken after 1 cycle, no STALL.
//  - Sweep:
//    - Stimulus: all 16 flag values x 6 COND x OP_TF {000,001,010,011,100,111,101}.
//    - Required: PC_LOAD matches the jf/jt truth table. j/jal/jr always taken; 111/101 never taken.

Source files
------------

// File: rtl/lapido_defs.sv
// Shared encodings for the jump controller and its taken/not-taken tester.
// Jump op codes, condition codes, controller states and flush-length helper.
package lapido_defs;

  typedef enum logic [2:0] {
    OP_JF   = 3'b000,
    OP_JT   = 3'b001,
    OP_J    = 3'b010,
    OP_JAL  = 3'b011,
    OP_JR   = 3'b100,
    OP_NONE = 3'b111
  } op_tf_e;

  typedef enum logic [2:0] {
    CND_TRUE  = 3'b000,
    CND_NEG   = 3'b001,
    CND_ZERO  = 3'b010,
    CND_CARRY = 3'b100,
    CND_NEGZ  = 3'b101,
    CND_OVF   = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITF   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam int FLAG_O = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // Out-of-range flush lengths collapse to a single cycle.
  function automatic logic [2:0] flush_len(input int n);
    if (n < 1 || n > 7) return 3'd1;
    return 3'(n);
  endfunction

endpackage

// File: rtl/tester_flags.sv
// Taken/not-taken tester: out=0 means the jump is taken.
// Decodes the jump op and evaluates the selected flag condition.
module tester_flags
  import lapido_defs::*;
(
  input  logic [2:0] op_tf,
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       out
);

  logic hit;
  logic is_jf;
  logic is_jt;
  logic is_uncond;

  always_comb begin
    hit = 1'b0;
    unique case (cond)
      CND_TRUE:  hit = 1'b1;
      CND_NEG:   hit = flags[FLAG_S];
      CND_ZERO:  hit = flags[FLAG_Z];
      CND_CARRY: hit = flags[FLAG_C];
      CND_NEGZ:  hit = flags[FLAG_S] & flags[FLAG_Z];
      CND_OVF:   hit = flags[FLAG_O];
      default:   hit = 1'b0;
    endcase
  end

  assign is_jf     = (op_tf == OP_JF);
  assign is_jt     = (op_tf == OP_JT);
  assign is_uncond = (op_tf == OP_J) |
                     (op_tf == OP_JAL) |
                     (op_tf == OP_JR);

  // Illegal and "none" ops fall to the default: never taken.
  always_comb begin
    out = 1'b1;
    unique case (1'b1)
      is_jf:     out = hit;
      is_jt:     out = ~hit;
      is_uncond: out = 1'b0;
      default:   out = 1'b1;
    endcase
  end

endmodule

// File: rtl/jump_controller.sv
// Jump controller: flag register, request capture, resolve and flush FSM.
// Define JUMP_FLAG_BYPASS_EN to forward same-cycle flags instead of stalling.
module jump_controller
  import lapido_defs::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLAG_WE,
  input  logic              O_IN,
  input  logic              S_IN,
  input  logic              C_IN,
  input  logic              Z_IN,
  input  logic              BR_VALID,
  output logic              BR_READY,
  input  logic [2:0]        OP_TF,
  input  logic [2:0]        COND,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic [ADDR_W-1:0] REG_TARGET,
  input  logic [ADDR_W-1:0] PC_PLUS1,
  output logic              PC_LOAD,
  output logic [ADDR_W-1:0] PC_NEXT,
  output logic              LINK_WE,
  output logic [ADDR_W-1:0] LINK_DATA,
  output logic              FLUSH,
  output logic              STALL,
  output logic [3:0]        FLAGS
);

  localparam logic [2:0] FLUSH_N = flush_len(FLUSH_CYCLES);

  state_e            state;
  state_e            state_nx;
  logic [3:0]        flags_q;
  logic [3:0]        flag_in;
  logic [3:0]        dec_flags;
  logic [2:0]        op_q;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] rtgt_q;
  logic [ADDR_W-1:0] link_q;
  logic [2:0]        cnt_q;
  logic              accept;
  logic              not_taken;
  logic              ready;
  logic              load;
  logic              link;
  logic              flush;
  logic              wait_st;
  logic              cnt_load;

  assign flag_in = {O_IN, S_IN, C_IN, Z_IN};
  assign accept  = BR_VALID & ready;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_q <= '0;
    end else if (FLAG_WE) begin
      flags_q <= flag_in;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q   <= OP_NONE;
      cond_q <= CND_TRUE;
      tgt_q  <= '0;
      rtgt_q <= '0;
      link_q <= '0;
    end else if (accept) begin
      op_q   <= OP_TF;
      cond_q <= COND;
      tgt_q  <= TARGET;
      rtgt_q <= REG_TARGET;
      link_q <= PC_PLUS1;
    end
  end

`ifdef JUMP_FLAG_BYPASS_EN
  logic [3:0] fcopy_q;

  // Private flag snapshot taken at accept, with same-cycle ALU flags forwarded.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fcopy_q <= '0;
    end else if (accept) begin
      fcopy_q <= FLAG_WE ? flag_in : flags_q;
    end
  end

  assign dec_flags = fcopy_q;
`else
  assign dec_flags = flags_q;
`endif

  tester_flags u_tester (
    .op_tf (op_q),
    .cond  (cond_q),
    .flags (dec_flags),
    .out   (not_taken)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    load     = 1'b0;
    link     = 1'b0;
    flush    = 1'b0;
    wait_st  = 1'b0;
    cnt_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (BR_VALID) begin
`ifdef JUMP_FLAG_BYPASS_EN
          state_nx = ST_RESOLVE;
`else
          state_nx = FLAG_WE ? ST_WAITF : ST_RESOLVE;
`endif
        end
      end
      ST_WAITF: begin
        wait_st  = 1'b1;
        state_nx = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (!not_taken) begin
          load     = 1'b1;
          link     = (op_q == OP_JAL);
          cnt_load = 1'b1;
          state_nx = ST_FLUSH;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt_q <= 3'd1) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= FLUSH_N;
    end else if (state == ST_FLUSH && cnt_q != 3'd0) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

  assign BR_READY  = ready;
  assign PC_LOAD   = load;
  assign LINK_WE   = link;
  assign FLUSH     = flush;
  assign STALL     = wait_st | (BR_VALID & ~ready);
  assign FLAGS     = flags_q;
  assign LINK_DATA = link_q;
  assign PC_NEXT   = !load ? '0 :
                     (op_q == OP_JR) ? rtgt_q : tgt_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: reset, taken/not-taken, jal, hazard, sweep.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_jump_controller;

  logic        CLK;
  logic        RESET;
  logic        FLAG_WE;
  logic        O_IN, S_IN, C_IN, Z_IN;
  logic        BR_VALID;
  logic        BR_READY;
  logic [2:0]  OP_TF;
  logic [2:0]  COND;
  logic [15:0] TARGET;
  logic [15:0] REG_TARGET;
  logic [15:0] PC_PLUS1;
  logic        PC_LOAD;
  logic [15:0] PC_NEXT;
  logic        LINK_WE;
  logic [15:0] LINK_DATA;
  logic        FLUSH;
  logic        STALL;
  logic [3:0]  FLAGS;

  int n_chk = 0;
  int n_err = 0;

  jump_controller #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FLAG_WE    (FLAG_WE),
    .O_IN       (O_IN),
    .S_IN       (S_IN),
    .C_IN       (C_IN),
    .Z_IN       (Z_IN),
    .BR_VALID   (BR_VALID),
    .BR_READY   (BR_READY),
    .OP_TF      (OP_TF),
    .COND       (COND),
    .TARGET     (TARGET),
    .REG_TARGET (REG_TARGET),
    .PC_PLUS1   (PC_PLUS1),
    .PC_LOAD    (PC_LOAD),
    .PC_NEXT    (PC_NEXT),
    .LINK_WE    (LINK_WE),
    .LINK_DATA  (LINK_DATA),
    .FLUSH      (FLUSH),
    .STALL      (STALL),
    .FLAGS      (FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {O_IN, S_IN, C_IN, Z_IN} = f;
    FLAG_WE = 1'b1;
    tick();
    FLAG_WE = 1'b0;
  endtask

  // Present one request for one edge; returns in the cycle after accept.
  task automatic issue(input logic [2:0] op, input logic [2:0] cnd,
                       input logic [15:0] tgt, input logic [15:0] rtgt,
                       input logic [15:0] pc1);
    OP_TF      = op;
    COND       = cnd;
    TARGET     = tgt;
    REG_TARGET = rtgt;
    PC_PLUS1   = pc1;
    BR_VALID   = 1'b1;
    tick();
    BR_VALID   = 1'b0;
    FLAG_WE    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!BR_READY && n < 20) begin
      tick();
      n++;
    end
    check(tag, BR_READY, 1);
  endtask

  function automatic bit exp_taken(input logic [2:0] op,
                                   input logic [2:0] cnd,
                                   input logic [3:0] f);
    bit c;
    case (cnd)
      3'b000:  c = 1'b1;
      3'b001:  c = f[2];
      3'b010:  c = f[0];
      3'b100:  c = f[1];
      3'b101:  c = f[2] & f[0];
      3'b111:  c = f[3];
      default: c = 1'b0;
    endcase
    case (op)
      3'b000:                 return !c;
      3'b001:                 return c;
      3'b010, 3'b011, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  initial begin
    logic [2:0] conds [6];
    logic [2:0] ops [7];
    bit t;
    conds = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
    ops   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b101};

    RESET = 1'b0;
    FLAG_WE = 1'b0;
    {O_IN, S_IN, C_IN, Z_IN} = 4'h0;
    BR_VALID = 1'b0;
    OP_TF = 3'b111;
    COND = 3'b000;
    TARGET = '0;
    REG_TARGET = '0;
    PC_PLUS1 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", BR_READY, 1);
    check("rst_flags", FLAGS, 0);
    check("rst_flush", FLUSH, 0);
    check("rst_pcload", PC_LOAD, 0);
    check("rst_stall", STALL, 0);
    check("rst_linkdata", LINK_DATA, 0);
    RESET = 1'b1;
    tick();

    // jt.zero with Z=1
    set_flags(4'b0001);
    check("flags_wr", FLAGS, 4'b0001);
    issue(3'b001, 3'b010, 16'h0040, 16'h9999, 16'h0011);
    check("jtz_pcload", PC_LOAD, 1);
    check("jtz_pcnext", PC_NEXT, 16'h0040);
    check("jtz_linkwe", LINK_WE, 0);
    check("jtz_ready", BR_READY, 0);
    BR_VALID = 1'b1;
    #1;
    check("busy_stall", STALL, 1);
    BR_VALID = 1'b0;
    tick();
    check("jtz_flush1", FLUSH, 1);
    check("jtz_pcload_off", PC_LOAD, 0);
    tick();
    check("jtz_flush2", FLUSH, 1);
    tick();
    check("jtz_flush_end", FLUSH, 0);
    check("jtz_ready_back", BR_READY, 1);

    // jf.carry with C=1: not taken
    set_flags(4'b0010);
    issue(3'b000, 3'b100, 16'h0050, 16'h0000, 16'h0012);
    check("jfc_pcload", PC_LOAD, 0);
    check("jfc_ready_resolve", BR_READY, 0);
    tick();
    check("jfc_ready", BR_READY, 1);
    check("jfc_flush", FLUSH, 0);

    // jr selects the register target
    issue(3'b100, 3'b000, 16'h1111, 16'h2222, 16'h0013);
    check("jr_pcnext", PC_NEXT, 16'h2222);
    drain("jr_drain");

    // jal, then async reset in the first flush cycle
    set_flags(4'b1111);
    issue(3'b011, 3'b000, 16'h0100, 16'h0000, 16'h0021);
    check("jal_pcload", PC_LOAD, 1);
    check("jal_linkwe", LINK_WE, 1);
    check("jal_linkdata", LINK_DATA, 16'h0021);
    check("jal_pcnext", PC_NEXT, 16'h0100);
    tick();
    check("jal_flush1", FLUSH, 1);
    check("jal_linkwe_off", LINK_WE, 0);
    RESET = 1'b0;
    #1;
    check("mid_rst_flush", FLUSH, 0);
    check("mid_rst_ready", BR_READY, 1);
    check("mid_rst_flags", FLAGS, 0);
    RESET = 1'b1;
    tick();
    check("post_rst_ready", BR_READY, 1);

    // FLAG_WE in RESOLVE: decision uses the pre-edge flags
    set_flags(4'b0000);
    issue(3'b001, 3'b010, 16'h0070, 16'h0000, 16'h0001);
    {O_IN, S_IN, C_IN, Z_IN} = 4'b0001;
    FLAG_WE = 1'b1;
    #1;
    check("res_we_pcload", PC_LOAD, 0);
    tick();
    FLAG_WE = 1'b0;
    check("res_we_flags", FLAGS, 4'b0001);
    drain("res_we_drain");

    // Flag hazard: FLAG_WE with Z_IN=1 on the accept cycle, old Z=0
    set_flags(4'b0000);
    {O_IN, S_IN, C_IN, Z_IN} = 4'b0001;
    FLAG_WE = 1'b1;
    issue(3'b001, 3'b010, 16'h0080, 16'h0000, 16'h0002);
`ifdef JUMP_FLAG_BYPASS_EN
    check("haz_stall", STALL, 0);
    check("haz_pcload", PC_LOAD, 1);
    check("haz_pcnext", PC_NEXT, 16'h0080);
`else
    check("haz_stall", STALL, 1);
    check("haz_pcload_wait", PC_LOAD, 0);
    tick();
    check("haz_stall_off", STALL, 0);
    check("haz_pcload", PC_LOAD, 1);
    check("haz_pcnext", PC_NEXT, 16'h0080);
`endif
    drain("haz_drain");

    // Sweep flags x conditions x ops
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 6; c++) begin
        for (int o = 0; o < 7; o++) begin
          set_flags(4'(f));
          issue(ops[o], conds[c], 16'h0A00 + 16'(o), 16'h0B00, 16'h0C00);
          t = exp_taken(ops[o], conds[c], 4'(f));
          check($sformatf("sweep_pl f%0h c%0d o%0d", f, conds[c], ops[o]),
                PC_LOAD, t);
          check($sformatf("sweep_lw f%0h c%0d o%0d", f, conds[c], ops[o]),
                LINK_WE, t && ops[o] == 3'b011);
          drain("sweep_drain");
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
